sensor_alarm_ctrl: RTL and testbench

Parametrised multi-channel sensor alarm controller. It qualifies N_CH sensor inputs with a consecutive-sample debounce and selects one channel by fixed priority. It then drives a one-hot buzzer output for a programmable hold time, and keeps a saturating count of raised alarms. It sits between the raw sensor pins and the buzzer/indicator pins in the tile top level.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_qualifier.sv | 49 ++++
 rtl/sensor_alarm_ctrl.sv | 106 ++++++++++
 tb/tb_sensor_alarm_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the sensor alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUAL  = 2'd1,
      ALARM = 2'd2
   } state_t;

   // {valid, index} of the lowest set bit; narrower vectors are zero-extended by the caller.
   function automatic logic [4:0] prio_enc(input logic [15:0] vec);
      logic [4:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--)
         if (vec[i]) r = {1'b1, 4'(i)};
      return r;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
      return (val >= max) ? max : val + 32'd1;
   endfunction

endpackage

// File: rtl/alarm_qualifier.sv
// Debounce qualifier: lowest-index candidate must be seen DEBOUNCE consecutive samples.
module alarm_qualifier
   import alarm_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int DEBOUNCE = 7,
   parameter int ID_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clear,
   input  logic [N_CH-1:0] i_sensor,
   output logic            o_valid,
   output logic            o_qual,
   output logic [ID_W-1:0] o_idx
);

   localparam int QW = $clog2(DEBOUNCE + 1);

   logic [4:0]      w_enc;
   logic [ID_W-1:0] w_idx;
   logic [QW-1:0]   w_cnt_nxt;
   logic [ID_W-1:0] r_cand;
   logic [QW-1:0]   r_qual_cnt;

   // An empty counter restarts at 1 regardless of the stale cand value.
   always_comb begin
      w_enc     = prio_enc(16'(i_sensor));
      w_idx     = ID_W'(w_enc[3:0]);
      w_cnt_nxt = (w_idx == r_cand) ? r_qual_cnt + QW'(1) : QW'(1);
   end

   assign o_valid = w_enc[4];
   assign o_idx   = w_idx;
   assign o_qual  = !i_clear && w_enc[4] && (w_cnt_nxt == QW'(DEBOUNCE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand     <= '0;
         r_qual_cnt <= '0;
      end else if (i_clear || !w_enc[4] || o_qual) begin
         r_qual_cnt <= '0;
      end else begin
         r_cand     <= w_idx;
         r_qual_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// Multi-channel sensor alarm controller: debounce, priority select, timed one-hot buzzer.
// Define ALARM_LATCH_EN to make the alarm latch until ack instead of timing out.
module sensor_alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int  N_CH        = 3,
   parameter int  DEBOUNCE    = 7,
   parameter int  HOLD_CYCLES = 31,
   parameter int  CNT_W       = 8,
   localparam int ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [N_CH-1:0]  i_sensor,
   input  logic             i_ack,
   output logic [N_CH-1:0]  o_buzzer,
   output logic             o_alarm_active,
   output logic [ID_W-1:0]  o_alarm_id,
   output logic [CNT_W-1:0] o_alarm_cnt
);

   state_t          r_state, w_state_nxt;
   logic            w_valid, w_qual, w_clear, w_enter, w_exit, w_timeout;
   logic [ID_W-1:0] w_idx;
   logic [N_CH-1:0]  r_buzzer;
   logic             r_alarm_active;
   logic [ID_W-1:0]  r_alarm_id;
   logic [CNT_W-1:0] r_alarm_cnt;

   // Qualifier is frozen while alarming so the exit edge never samples sensors.
   assign w_clear = !i_en || (r_state == ALARM);

   alarm_qualifier #(.N_CH(N_CH), .DEBOUNCE(DEBOUNCE), .ID_W(ID_W)) u_qual (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_sensor(i_sensor),
      .o_valid (w_valid),
      .o_qual  (w_qual),
      .o_idx   (w_idx)
   );

`ifdef ALARM_LATCH_EN
   assign w_timeout = 1'b0;
`else
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   logic [HW-1:0] r_hold_cnt;

   assign w_timeout = (r_hold_cnt == HW'(HOLD_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_hold_cnt <= '0;
      else if (!i_en)                        r_hold_cnt <= '0;
      else if (w_enter)                      r_hold_cnt <= HW'(1);
      else if (r_state == ALARM && !w_exit)  r_hold_cnt <= r_hold_cnt + HW'(1);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_en) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_qual) w_state_nxt = ALARM; else if (w_valid) w_state_nxt = QUAL;
            QUAL:    if (w_qual) w_state_nxt = ALARM; else if (!w_valid) w_state_nxt = IDLE;
            ALARM:   if (i_ack || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_enter = (r_state != ALARM) && (w_state_nxt == ALARM);
      w_exit  = (r_state == ALARM) && (w_state_nxt != ALARM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buzzer       <= '0;
         r_alarm_active <= 1'b0;
         r_alarm_id     <= '0;
         r_alarm_cnt    <= '0;
      end else if (w_enter) begin
         r_buzzer       <= N_CH'(1) << w_idx;
         r_alarm_active <= 1'b1;
         r_alarm_id     <= w_idx;
         r_alarm_cnt    <= CNT_W'(sat_inc(32'(r_alarm_cnt), 32'({CNT_W{1'b1}})));
      end else if (w_exit || !i_en) begin
         r_buzzer       <= '0;
         r_alarm_active <= 1'b0;
      end
   end

   assign o_buzzer       = r_buzzer;
   assign o_alarm_active = r_alarm_active;
   assign o_alarm_id     = r_alarm_id;
   assign o_alarm_cnt    = r_alarm_cnt;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Randomized bench for sensor_alarm_ctrl with a behavioural reference model and directed anchors.
module tb_sensor_alarm_ctrl;

   localparam int N_CH = 3, DEB = 7, HOLD = 31, CNT_W = 2, CNT_MAX = 3;
`ifdef ALARM_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_en = 1'b1;
   logic [N_CH-1:0]  i_sensor = '0;
   logic             i_ack = 1'b0;
   logic [N_CH-1:0]  o_buzzer;
   logic             o_alarm_active;
   logic [1:0]       o_alarm_id;
   logic [CNT_W-1:0] o_alarm_cnt;

   int checks = 0, errors = 0;
   bit chk_on = 1'b0;

   sensor_alarm_ctrl #(.N_CH(N_CH), .DEBOUNCE(DEB), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_en          (i_en),
      .i_sensor      (i_sensor),
      .i_ack         (i_ack),
      .o_buzzer      (o_buzzer),
      .o_alarm_active(o_alarm_active),
      .o_alarm_id    (o_alarm_id),
      .o_alarm_cnt   (o_alarm_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: an alarm fires once the same lowest-index channel has been seen DEB times in a row
   // while not alarming; it lasts HOLD edges unless cut short by ack or en.
   bit        m_alarm;
   int        m_streak, m_cand, m_elapsed, m_cnt;
   int        m_buz, m_act, m_id;

   function automatic int lowest(input logic [N_CH-1:0] s);
      int r;
      r = -1;
      for (int i = N_CH - 1; i >= 0; i--) if (s[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_alarm = 0; m_streak = 0; m_cand = 0; m_elapsed = 0;
      m_cnt = 0; m_buz = 0; m_act = 0; m_id = 0;
   endtask

   task automatic model_step();
      int c;
      if (!i_en) begin
         m_alarm = 0; m_streak = 0; m_buz = 0; m_act = 0;
      end else if (m_alarm) begin
         if (i_ack || (!LATCH && m_elapsed >= HOLD)) begin
            m_alarm = 0; m_buz = 0; m_act = 0; m_streak = 0;
         end else m_elapsed++;
      end else begin
         c = lowest(i_sensor);
         if (c < 0) m_streak = 0;
         else if (m_streak > 0 && c == m_cand) m_streak++;
         else begin m_cand = c; m_streak = 1; end
         if (m_streak == DEB) begin
            m_alarm = 1; m_elapsed = 1; m_streak = 0;
            m_buz = 1 << c; m_act = 1; m_id = c;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_buzzer", int'(o_buzzer), m_buz);
         chk("model_active", int'(o_alarm_active), m_act);
         chk("model_id", int'(o_alarm_id), m_id);
         chk("model_cnt", int'(o_alarm_cnt), m_cnt);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic quiesce();
      i_sensor = '0; i_ack = 1'b0; i_en = 1'b0;
      step(1);
      i_en = 1'b1;
      step(1);
   endtask

   initial begin
      #12;
      chk("rst_buzzer", int'(o_buzzer), 0);
      chk("rst_active", int'(o_alarm_active), 0);
      chk("rst_id", int'(o_alarm_id), 0);
      chk("rst_cnt", int'(o_alarm_cnt), 0);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;
      step(2);

`ifndef ALARM_LATCH_EN
      // Steady channel 1: rise at 7, fall at 38, re-rise at 45.
      i_sensor = 3'b010;
      step(6);  chk("a_e6_buzzer", int'(o_buzzer), 0);
      step(1);  chk("a_e7_buzzer", int'(o_buzzer), 2);
      chk("a_e7_id", int'(o_alarm_id), 1);
      chk("a_e7_cnt", int'(o_alarm_cnt), 1);
      step(30); chk("a_e37_buzzer", int'(o_buzzer), 2);
      step(1);  chk("a_e38_buzzer", int'(o_buzzer), 0);
      chk("a_e38_active", int'(o_alarm_active), 0);
      step(6);  chk("a_e44_buzzer", int'(o_buzzer), 0);
      step(1);  chk("a_e45_buzzer", int'(o_buzzer), 2);
      chk("a_e45_cnt", int'(o_alarm_cnt), 2);
      quiesce();

      // Candidate switch restarts the debounce.
      i_sensor = 3'b001;
      step(4); i_sensor = 3'b100;
      step(3); chk("b_e7_buzzer", int'(o_buzzer), 0);
      step(3); chk("b_e10_buzzer", int'(o_buzzer), 0);
      step(1); chk("b_e11_buzzer", int'(o_buzzer), 4);
      chk("b_e11_id", int'(o_alarm_id), 2);
      chk("b_e11_cnt", int'(o_alarm_cnt), 3);
      quiesce();

      // Priority between two channels; fourth alarm saturates the counter.
      i_sensor = 3'b110;
      step(7); chk("c_prio_buzzer", int'(o_buzzer), 2);
      chk("c_sat_cnt", int'(o_alarm_cnt), 3);
      quiesce();
      i_sensor = 3'b110;
      step(4); i_sensor = 3'b000;
      step(10); chk("c_drop_buzzer", int'(o_buzzer), 0);
      chk("c_drop_active", int'(o_alarm_active), 0);
      quiesce();

      // ack at edge 20 aborts; ack in IDLE does nothing.
      i_sensor = 3'b100;
      step(7);  chk("d_alarm_buzzer", int'(o_buzzer), 4);
      step(12); i_ack = 1'b1; i_sensor = 3'b000;
      step(1);  chk("d_ack_buzzer", int'(o_buzzer), 0);
      chk("d_ack_id", int'(o_alarm_id), 2);
      step(3);  chk("d_idle_ack_active", int'(o_alarm_active), 0);
      i_ack = 1'b0;
      quiesce();

      // en dropped mid-alarm.
      i_sensor = 3'b001;
      step(7); chk("e_alarm_buzzer", int'(o_buzzer), 1);
      step(5); i_en = 1'b0;
      step(1); chk("e_en_buzzer", int'(o_buzzer), 0);
      chk("e_en_active", int'(o_alarm_active), 0);
      chk("e_en_cnt", int'(o_alarm_cnt), 3);
      i_en = 1'b1; i_sensor = 3'b000;
      step(2);
`else
      // Latched alarm persists until ack.
      i_sensor = 3'b001;
      step(7);   chk("l_e7_buzzer", int'(o_buzzer), 1);
      step(112); chk("l_e119_buzzer", int'(o_buzzer), 1);
      i_ack = 1'b1;
      step(1);   chk("l_ack_buzzer", int'(o_buzzer), 0);
      i_ack = 1'b0; i_sensor = 3'b000;
      step(2);
`endif

      // Asynchronous reset during qualification.
      i_sensor = 3'b001;
      step(3);
      #2 rst_n = 1'b0;
      #1;
      chk("r_async_buzzer", int'(o_buzzer), 0);
      chk("r_async_active", int'(o_alarm_active), 0);
      chk("r_async_id", int'(o_alarm_id), 0);
      chk("r_async_cnt", int'(o_alarm_cnt), 0);
      rst_n = 1'b1; i_sensor = 3'b000;
      step(2);

      // Randomized traffic, checked every cycle by the model compare.
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(15) == 0) i_sensor = N_CH'($urandom_range(7));
         i_ack = ($urandom_range(39) == 0);
         i_en  = ($urandom_range(99) != 0);
         if ($urandom_range(1499) == 0) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         step(1);
      end
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
